// File: rtl/shared_add_pkg.sv
// Shared definitions for the time-shared adder: default sizes, the
// result-register state encoding and the tag-width helper.
package shared_add_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NCH   = 2;

    // Result register occupancy; FULL means out_valid is high.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_t;

    // Ceiling log2 with a floor of 1 so a tag always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_add_arb_rr_arbiter.sv
// Round-robin arbiter: the pointer names the highest-priority channel; the
// first requesting channel at or after it wins. The pointer moves one past
// the winner only when the grant is actually taken (advance).
module rr_arbiter
    import shared_add_pkg::*;
#(
    parameter  int N  = DEF_NCH,
    localparam int CW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt_comb,
    output logic [CW-1:0] idx
);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] cand_idx;
    logic          found;
    int            cand;

    // Masked priority search: scan from the pointer, wrapping modulo N.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would infer a latch.
        gnt_comb = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = CW'(cand);
            if (!found && req[cand_idx]) begin
                found              = 1'b1;
                idx                = cand_idx;
                gnt_comb[cand_idx] = 1'b1;
            end
        end
    end

    // Pointer register: advance past the winner when the grant is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (idx == CW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/shared_add_arb.sv
// Time-shared adder: NCH operand-pair channels share one WIDTH-bit adder
// through a round-robin arbiter, feeding a one-entry result register with
// valid/ready backpressure and a channel tag.
// Optional feature: define SHARED_ADD_SUB_EN to add per-channel subtract
// (sub_bus input, out_sub output).
module shared_add_arb
    import shared_add_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NCH   = DEF_NCH,
    localparam int CH_W  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] a_bus,
    input  logic [NCH*WIDTH-1:0] b_bus,
    output logic [NCH-1:0]       gnt,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SHARED_ADD_SUB_EN
    input  logic [NCH-1:0]       sub_bus,
    output logic                 out_sub,
`endif
    output logic [WIDTH:0]       out_sum,
    output logic [CH_W-1:0]      out_ch
);

    res_state_t     state_q;
    res_state_t     state_d;
    logic           acc;
    logic [NCH-1:0] gnt_comb;
    logic [CH_W-1:0] idx;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   sum_d;

    // A new pair is taken when someone requests and the register is free
    // or draining this same cycle.
    assign acc       = (|req) && ((state_q == ST_EMPTY) || out_ready);
    assign out_valid = (state_q == ST_FULL);

    rr_arbiter #(.N(NCH)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .advance  (acc),
        .gnt_comb (gnt_comb),
        .idx      (idx)
    );

    // Operand mux: pick the winning channel's pair.
    assign a_sel = a_bus[idx*WIDTH +: WIDTH];
    assign b_sel = b_bus[idx*WIDTH +: WIDTH];

`ifdef SHARED_ADD_SUB_EN
    logic sub_sel;
    assign sub_sel = sub_bus[idx];
    // Zero-extended operands give an unsigned sum or a signed difference.
    assign sum_d = sub_sel ? ({1'b0, a_sel} - {1'b0, b_sel})
                           : ({1'b0, a_sel} + {1'b0, b_sel});
`else
    // Zero-extended operands keep the carry in the MSB.
    assign sum_d = {1'b0, a_sel} + {1'b0, b_sel};
`endif

    // Result register occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy: fill on accept, drain when the consumer takes it.
    always_comb begin
        state_d = state_q;
        if (acc) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Result, tag and grant pulse; result holds whenever nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: payload flops are often left unreset, but these drive outputs that must read zero after reset, so they are cleared.
        if (!rst_n) begin
            gnt     <= '0;
            out_sum <= '0;
            out_ch  <= '0;
`ifdef SHARED_ADD_SUB_EN
            out_sub <= 1'b0;
`endif
        end else begin
            gnt <= acc ? gnt_comb : '0;
            if (acc) begin
                out_sum <= sum_d;
                out_ch  <= idx;
`ifdef SHARED_ADD_SUB_EN
                out_sub <= sub_sel;
`endif
            end
        end
    end

endmodule

// File: doc/shared_add_arb.md
Name: shared_add_arb

Overview:
- Time-shared adder serving NCH operand-pair channels through one WIDTH-bit adder.
- Parametrised successor to the two-channel mux-plus-1-bit-adder datapath. Adds per-channel requests, a round-robin arbiter, a registered result with valid/ready backpressure, and a channel tag.
- Sits between several lab-level producers and a single result consumer, for example a display or accumulator stage.

Parameters:
- WIDTH, 4, operand width in bits (≥1).
- NCH, 2, number of requesting channels (2..16).
- CH_W, derived as clog2(NCH) (min 1), channel tag width. Not user-overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- req  in  NCH  per-channel request; bit i asserts that channel i has an operand pair.
- a_bus  in  NCH*WIDTH  operand A per channel; channel i occupies bits [i*WIDTH +: WIDTH].
- b_bus  in  NCH*WIDTH  operand B per channel, same packing.
- gnt  out  NCH  one-hot, registered; channel i's operands were captured on the previous edge.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_sum  out  WIDTH+1  result; MSB is the carry out (or sign, see Optional Feature).
- out_ch  out  CH_W  index of the channel that produced out_sum.
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - gnt=0, out_valid=0, out_sum=0, out_ch=0.
  - Arbiter pointer=0, meaning channel 0 has highest priority first.
- Reset mid-operation discards any held result. No partial state survives.
- Result register is one entry with two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Accept condition: acc = (|req) && (EMPTY || out_ready).
  - The result register can be refilled in the same cycle it drains, giving full throughput.
- On an edge where acc=1:
  - Arbiter picks winner w, the first set req bit at or after the pointer, wrapping modulo NCH.
  - out_sum <= {1'b0,a_w} + {1'b0,b_w}.
  - out_ch <= w.
  - out_valid <= 1.
  - gnt <= onehot(w).
  - Pointer <= (w+1) mod NCH.
- On an edge where acc=0:
  - gnt <= 0.
  - If FULL && out_ready, go to EMPTY (out_valid <= 0). out_sum and out_ch hold their last values.
  - If FULL && !out_ready, hold out_sum, out_ch and out_valid stable. Stable hold is mandatory.
- Latency: operands sampled on edge k, result visible after edge k. That is one cycle from req to out_valid.
- Requester handshake:
  - A requester holds req and its operands stable until it sees gnt[i]=1 for one cycle.
  - It may then drop req or present the next pair.
  - gnt is a single-cycle pulse per accepted transaction.
- Fairness: a continuously requesting channel is served within NCH accepts.
- Boundary cases:
  - Single requester: served every accepting cycle. Pointer still advances past it.
  - All requesters active: strict rotation 0,1,…,NCH-1,0,…
  - No request with out_ready=1: the register drains and the block idles.
  - Arithmetic: the sum is unsigned and never overflows; carry goes in out_sum[WIDTH]. For example, WIDTH=4 with 15+15 gives 5'b11110.
  - With NCH not a power of two, unused tag codes never appear on out_ch.

Optional Feature:
- Macro: SHARED_ADD_SUB_EN.
- With the macro defined:
  - Adds input port sub_bus (NCH bits).
  - Channel i subtracts when sub_bus[i]=1: out_sum <= {1'b0,a} - {1'b0,b}, a WIDTH+1-bit two's-complement result whose MSB is the sign (a<b gives negative).
  - sub_bus[i] obeys the same stability rule as the operands.
  - Adds output out_sub, registered alongside out_ch, reporting the op performed.
- Without the macro: the sub_bus and out_sub ports are absent and the block is add-only, identical to the behaviour above.

Decomposition:
- Package shared_add_pkg holds:
  - Function clog2 for CH_W.
  - State encoding constants ST_EMPTY=1'b0, ST_FULL=1'b1.
  - Default parameter constants.
- Sub-module rr_arbiter (parameter N) covers the pointer register, masked priority search, winner index and one-hot output.
  - Its interface: clk, rst_n, req, advance (=acc), gnt_comb, idx.
- Top level holds the operand mux (indexed part-select), the adder/subtractor and the result/valid register.

Test Plan (all at WIDTH=4, NCH=4):
- Reset: assert rst_n=0 asynchronously mid-cycle while FULL -> out_valid=0, gnt=0, out_sum=0 immediately; after release, the first grant goes to channel 0.
- Single add: req=4'b0100, a2=9, b2=8, out_ready=1 -> next cycle out_valid=1, out_sum=5'b10001, out_ch=2, gnt=4'b0100 for exactly one cycle.
- Round-robin: req=4'b1111 held with out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; one result per cycle.
- Backpressure: FULL with out_sum=7, out_ready=0 for 5 cycles, req=4'b0010 -> out_sum/out_ch stable, gnt=0; on out_ready=1 the same edge captures channel 1 and gnt=4'b0010.
- Boundary: a=15, b=15 -> out_sum=30 (5'b11110); a=0, b=0 -> out_sum=0 with out_valid=1.
- SHARED_ADD_SUB_EN: sub_bus[3]=1, a3=3, b3=5 -> out_sum=5'b11110 (−2), out_sub=1; without the macro, the same stimulus gives 8.
